syncro_filt: RTL and testbench
==============================

// Module: syncro_filt
// PURPOSE
//  Parametrised multi-bit input conditioner for asynchronous signals (probe inputs, external triggers).
//  - Per-bit N-stage FF synchroniser, then an optional per-bit glitch filter (stable-count debounce),
//    then optional single-cycle rise/fall pulse outputs.
//  - Sits between the device pins and the sampler/trigger logic in the clk_i domain.
// PARAMETERS
//  WIDTH       32   number of independent channels (bits)
//  STAGES      2    synchroniser depth; legal >= 2 (elaboration error otherwise)
//  FILT_CYCLES 0    consecutive cycles a new synced value must persist before sync_o follows; 0 = filter bypassed
//  INIT_VAL    '0   reset value of all sync stages, filter state and sync_o (WIDTH bits)
// PORTS
//  clk_i    in   1      system clock
//  rst_in   in   1      asynchronous reset, active low
//  async_i  in   WIDTH  asynchronous inputs, no timing relation to clk_i
//  sync_o   out  WIDTH  synchronised (and filtered) value
//  rise_o   out  WIDTH  per-bit 1-cycle pulse: sync_o bit went 0->1 this cycle
//  fall_o   out  WIDTH  per-bit 1-cycle pulse: sync_o bit went 1->0 this cycle
// BEHAVIOUR
//  - Reset: async assert of rst_in clears immediately, no clock needed:
//    all stages = INIT_VAL, sync_o = INIT_VAL, filter counters = 0, edge history = INIT_VAL,
//    rise_o = fall_o = 0. Deassert is synchronised externally; block needs no extra cycles.
//  - Sync chain: s[0] <= async_i, s[k] <= s[k-1]; synced value S = s[STAGES-1].
//    No logic between stages; only the chain's first FF samples async_i.
//  - Filter, FILT_CYCLES = 0: sync_o = S (registered stage, no extra delay).
//  - Filter, FILT_CYCLES >= 1, per bit, counter width $clog2(FILT_CYCLES+1):
//    - S == sync_o: cnt <= 0.
//    - S != sync_o and cnt < FILT_CYCLES-1: cnt <= cnt+1.
//    - S != sync_o and cnt == FILT_CYCLES-1: sync_o <= S, cnt <= 0.
//    - A return of S to sync_o before the terminal count aborts the change (cnt back to 0);
//      pulses shorter than FILT_CYCLES cycles at S never reach sync_o.
//    - Counter never wraps; bits are fully independent.
//  - Latency: async_i change stable before clock edge k appears on sync_o after edge
//    k+STAGES-1 (FILT_CYCLES=0) or k+STAGES-1+FILT_CYCLES (FILT_CYCLES>=1).
//  - Edges: prev <= sync_o each cycle; rise_o = sync_o & ~prev, fall_o = ~sync_o & prev
//    (same cycle sync_o changes, exactly one cycle wide). No pulse on reset release.
//  - Simultaneous changes on several bits: each bit filtered and pulsed independently, same cycle allowed.
//  - Reset mid-filter-count: count discarded, sync_o returns to INIT_VAL, no pulse generated.
// CONFIGURATION
//  LOGIP_SYNCRO_EDGE_EN
//  - defined: edge history register and rise_o/fall_o logic as above.
//  - undefined: no edge registers instantiated; rise_o and fall_o tied to '0; sync_o unaffected.
// TESTING
//  1. STAGES=2,FILT=0: reset, async_i 0->32'hA5A5_0001 before edge 0 -> sync_o updates after edge 1, not earlier.
//  2. STAGES=3,FILT=4: bit0 high 3 cycles then low -> sync_o[0] stays 0, no rise_o;
//     high 4+ cycles -> sync_o[0]=1 after edge k+6.
//  3. EDGE_EN, FILT=0: bit3 0->1->0 with 5-cycle high -> rise_o[3] one cycle, fall_o[3] one cycle 5 later, others 0.
//  4. INIT_VAL=32'hFFFF_FFFF, async_i=0 at release -> sync_o starts FFFF_FFFF, fall_o all bits exactly once.
//  5. FILT=4, rst_in low after 2 counted cycles -> sync_o=INIT_VAL at once, pulses 0, restart needs full 4.
//  6. EDGE_EN undefined: repeat test 3 -> rise_o=fall_o=0 throughout, sync_o identical to test 3.

Source files
------------

// File: rtl/syncro_filt.sv
// Multi-bit input conditioner: per-bit N-stage synchroniser, optional stable-count glitch filter
// and optional rise/fall pulses (edge logic present only when LOGIP_SYNCRO_EDGE_EN is defined).
module syncro_filt #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      STAGES      = 2,
    parameter int unsigned      FILT_CYCLES = 0,
    parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    if (STAGES < 2) begin : g_stages_chk
        $error("syncro_filt: STAGES must be >= 2");
    end

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]             synced;

    // Plain FF chain: only stage 0 ever sees async_i, nothing sits between stages.
    always_comb begin
        sync_d[0] = async_i;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= {STAGES{INIT_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign synced = sync_q[STAGES-1];

    if (FILT_CYCLES == 0) begin : g_no_filt
        assign sync_o = synced;
    end else begin : g_filt
        localparam int unsigned     CW       = $clog2(FILT_CYCLES + 1);
        localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CYCLES - 1);

        logic [WIDTH-1:0][CW-1:0] cnt_q;
        logic [WIDTH-1:0][CW-1:0] cnt_d;
        logic [WIDTH-1:0]         filt_q;
        logic [WIDTH-1:0]         filt_d;

        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            for (int b = 0; b < WIDTH; b++) begin
                if (synced[b] == filt_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CNT_LAST) begin
                    filt_d[b] = synced[b];
                    cnt_d[b]  = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
        end

        // NOTE: the counter array is control state, so it is reset like any other flop.
        always_ff @(posedge clk_i or negedge rst_in) begin
            if (!rst_in) begin
                cnt_q  <= '0;
                filt_q <= INIT_VAL;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign sync_o = filt_q;
    end

`ifdef LOGIP_SYNCRO_EDGE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        prev_d = sync_o;
    end

    // History resets to INIT_VAL so reset release never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            prev_q <= INIT_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_syncro_filt.sv
// Directed bench for syncro_filt: three instances cover latency, filtering, edges and INIT_VAL.
module tb_syncro_filt;

`ifdef LOGIP_SYNCRO_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [31:0] async_a, sync_a, rise_a, fall_a;
    logic [31:0] async_b, sync_b, rise_b, fall_b;
    logic [31:0] async_c, sync_c, rise_c, fall_c;

    int checks = 0;
    int errors = 0;

    // A: STAGES=2, no filter, INIT 0.
    syncro_filt #(.WIDTH(32), .STAGES(2), .FILT_CYCLES(0), .INIT_VAL(32'h0)) dut_a (
        .clk_i(clk), .rst_in(rst_n), .async_i(async_a),
        .sync_o(sync_a), .rise_o(rise_a), .fall_o(fall_a)
    );

    // B: STAGES=3, 4-cycle filter, INIT 0.
    syncro_filt #(.WIDTH(32), .STAGES(3), .FILT_CYCLES(4), .INIT_VAL(32'h0)) dut_b (
        .clk_i(clk), .rst_in(rst_n), .async_i(async_b),
        .sync_o(sync_b), .rise_o(rise_b), .fall_o(fall_b)
    );

    // C: STAGES=2, no filter, INIT all ones.
    syncro_filt #(.WIDTH(32), .STAGES(2), .FILT_CYCLES(0), .INIT_VAL(ONES)) dut_c (
        .clk_i(clk), .rst_in(rst_n), .async_i(async_c),
        .sync_o(sync_c), .rise_o(rise_c), .fall_o(fall_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        async_a = '0;
        async_b = '0;
        async_c = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        async_a = '0;
        async_b = '0;
        async_c = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (sync_a !== 32'h0 || rise_a !== 32'h0 || fall_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: sync=%h rise=%h fall=%h expected all 0", sync_a, rise_a, fall_a);
        end
        checks++;
        if (sync_b !== 32'h0 || rise_b !== 32'h0 || fall_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: sync=%h rise=%h fall=%h expected all 0", sync_b, rise_b, fall_b);
        end
        checks++;
        if (sync_c !== ONES || rise_c !== 32'h0 || fall_c !== 32'h0) begin
            errors++;
            $display("FAIL reset_c: sync=%h rise=%h fall=%h expected ffffffff/0/0",
                     sync_c, rise_c, fall_c);
        end
        rst_n = 1'b1;
    endtask

    // Runs straight after release from test_reset with async_c held at 0.
    task automatic test_init_val();
        logic [31:0] exp_sync, exp_fall;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_sync = (i == 0) ? ONES : 32'h0;
            exp_fall = (EDGE_EN && i == 1) ? ONES : 32'h0;
            checks++;
            if (sync_c !== exp_sync || fall_c !== exp_fall || rise_c !== 32'h0) begin
                errors++;
                $display("FAIL init_val cyc%0d: sync=%h fall=%h rise=%h expected %h/%h/0",
                         i, sync_c, fall_c, rise_c, exp_sync, exp_fall);
            end
        end
    endtask

    task automatic test_sync_latency();
        pulse_reset();
        async_a = 32'hA5A5_0001;
        @(negedge clk);
        checks++;
        if (sync_a !== 32'h0) begin
            errors++;
            $display("FAIL latency_early: sync=%h expected 00000000", sync_a);
        end
        @(negedge clk);
        checks++;
        if (sync_a !== 32'hA5A5_0001 || rise_a !== (EDGE_EN ? 32'hA5A5_0001 : 32'h0)) begin
            errors++;
            $display("FAIL latency_edge1: sync=%h rise=%h expected a5a50001 edge_en=%0d",
                     sync_a, rise_a, EDGE_EN);
        end
        @(negedge clk);
        checks++;
        if (sync_a !== 32'hA5A5_0001 || rise_a !== 32'h0 || fall_a !== 32'h0) begin
            errors++;
            $display("FAIL latency_hold: sync=%h rise=%h fall=%h expected a5a50001/0/0",
                     sync_a, rise_a, fall_a);
        end
    endtask

    task automatic test_edges();
        logic [31:0] exp_sync, exp_rise, exp_fall;
        pulse_reset();
        async_a = 32'h0000_0008;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_sync = (i >= 1 && i <= 5) ? 32'h8 : 32'h0;
            exp_rise = (EDGE_EN && i == 1) ? 32'h8 : 32'h0;
            exp_fall = (EDGE_EN && i == 6) ? 32'h8 : 32'h0;
            checks++;
            if (sync_a !== exp_sync || rise_a !== exp_rise || fall_a !== exp_fall) begin
                errors++;
                $display("FAIL edges cyc%0d: sync=%h rise=%h fall=%h expected %h/%h/%h",
                         i, sync_a, rise_a, fall_a, exp_sync, exp_rise, exp_fall);
            end
            if (i == 4) async_a = 32'h0;
        end
    endtask

    task automatic test_filter_short();
        pulse_reset();
        async_b = 32'h1;
        repeat (3) @(negedge clk);
        async_b = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sync_b !== 32'h0 || rise_b !== 32'h0 || fall_b !== 32'h0) begin
                errors++;
                $display("FAIL filter_short cyc%0d: sync=%h rise=%h fall=%h expected 0/0/0",
                         i, sync_b, rise_b, fall_b);
            end
        end
    endtask

    task automatic test_filter_long();
        logic [31:0] exp_sync, exp_rise;
        pulse_reset();
        async_b = 32'h1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_sync = (i >= 6) ? 32'h1 : 32'h0;
            exp_rise = (EDGE_EN && i == 6) ? 32'h1 : 32'h0;
            checks++;
            if (sync_b !== exp_sync || rise_b !== exp_rise) begin
                errors++;
                $display("FAIL filter_long cyc%0d: sync=%h rise=%h expected %h/%h",
                         i, sync_b, rise_b, exp_sync, exp_rise);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] exp_sync, exp_rise;
        pulse_reset();
        async_b = 32'h2;
        repeat (8) @(negedge clk);
        checks++;
        if (sync_b !== 32'h2) begin
            errors++;
            $display("FAIL midcnt_setup: sync=%h expected 00000002", sync_b);
        end
        async_b = 32'h3;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sync_b !== 32'h0 || rise_b !== 32'h0 || fall_b !== 32'h0) begin
            errors++;
            $display("FAIL midcnt_async_rst: sync=%h rise=%h fall=%h expected 0/0/0",
                     sync_b, rise_b, fall_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_sync = (i >= 6) ? 32'h3 : 32'h0;
            exp_rise = (EDGE_EN && i == 6) ? 32'h3 : 32'h0;
            checks++;
            if (sync_b !== exp_sync || rise_b !== exp_rise || fall_b !== 32'h0) begin
                errors++;
                $display("FAIL midcnt_restart cyc%0d: sync=%h rise=%h fall=%h expected %h/%h/0",
                         i, sync_b, rise_b, fall_b, exp_sync, exp_rise);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_val();
        test_sync_latency();
        test_edges();
        test_filter_short();
        test_filter_long();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
